// File: rtl/usbfs_debug_pkg.sv
// Shared types and ASCII helpers for the USB debug hex text formatter.
package usbfs_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HI,
    ST_LO,
    ST_SEP,
    ST_BANG,
    ST_NL
  } state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_BANG  = 8'h21;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  function automatic logic [7:0] hex_nibble_to_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return ASCII_0 + {4'h0, nibble};
    end else begin
      return ASCII_A + {4'h0, nibble} - 8'd10;
    end
  endfunction

endpackage

// File: rtl/usbfs_debug_byte_fifo.sv
// 9-bit {last, byte} FIFO with a registered read port so the array maps onto block RAM.
module usbfs_debug_byte_fifo
  import usbfs_debug_pkg::*;
#(
  parameter int ISIZE = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wr_en,
  input  logic [8:0] i_wr_data,
  input  logic       i_rd_en,
  output logic [8:0] o_rd_data,
  output logic       o_full,
  output logic       o_empty
);
  localparam int DEPTH = 1 << ISIZE;

  logic [8:0]     r_mem [0:DEPTH-1];
  logic [ISIZE:0] r_wr_ptr;
  logic [ISIZE:0] r_rd_ptr;
  logic [8:0]     r_rd_data;

  // The extra pointer bit tells a full ring apart from an empty one.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[ISIZE] != r_rd_ptr[ISIZE]) &&
                     (r_wr_ptr[ISIZE-1:0] == r_rd_ptr[ISIZE-1:0]);
  assign o_rd_data = r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[r_wr_ptr[ISIZE-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_data <= '0;
    end else begin
      if (i_wr_en) begin
        r_wr_ptr <= r_wr_ptr + (ISIZE+1)'(1);
      end
      if (i_rd_en) begin
        r_rd_data <= r_mem[r_rd_ptr[ISIZE-1:0]];
        r_rd_ptr  <= r_rd_ptr + (ISIZE+1)'(1);
      end
    end
  end

endmodule

// File: rtl/usbfs_debug_hex_formatter.sv
// Renders captured USB bytes as "HH " hex text for the debug UART and marks
// FIFO overflow losses with a "!\n" line terminator.
module usbfs_debug_hex_formatter
  import usbfs_debug_pkg::*;
#(
  parameter int ISIZE          = 6,
  parameter int BYTES_PER_LINE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  input  logic        tx_rdy,
  output logic [15:0] drop_cnt
);
  localparam logic [7:0] LP_BPL = 8'(BYTES_PER_LINE);

  state_e      r_state;
  state_e      w_next_state;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_drop;
  logic        w_pop;
  logic        w_emit;
  logic        w_fire;
  logic        w_sep_nl;
  logic [7:0]  w_char;
  logic [8:0]  w_rd_data;
  logic [7:0]  r_byte;
  logic        r_last;
  logic [7:0]  r_line_cnt;
  logic        r_drop_pending;
  logic [15:0] r_drop_cnt;

  // Fullness is judged on the current pointers, so a pop in the same cycle
  // cannot rescue an incoming byte.
  assign w_push   = in_valid & ~w_full;
  assign w_drop   = in_valid & w_full;
  assign w_sep_nl = r_last | ((r_line_cnt + 8'd1) == LP_BPL);

  // TX handshake: a character transfers on each clock where tx_en=1; tx_en is
  // only raised while tx_rdy=1, and tx_data stays put while an emit waits.
  assign w_fire   = w_emit & tx_rdy;
  assign tx_en    = w_fire;
  assign tx_data  = w_char;
  assign drop_cnt = r_drop_cnt;

  usbfs_debug_byte_fifo #(
    .ISIZE (ISIZE)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_push),
    .i_wr_data ({in_last, in_byte}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_emit       = 1'b0;
    w_char       = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (r_drop_pending) begin
          w_next_state = ST_BANG;
        end else if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_FETCH;
        end
      end
      ST_FETCH: w_next_state = ST_HI;
      ST_HI: begin
        w_emit = 1'b1;
        w_char = hex_nibble_to_ascii(r_byte[7:4]);
        if (tx_rdy) w_next_state = ST_LO;
      end
      ST_LO: begin
        w_emit = 1'b1;
        w_char = hex_nibble_to_ascii(r_byte[3:0]);
        if (tx_rdy) w_next_state = ST_SEP;
      end
      ST_SEP: begin
        w_emit = 1'b1;
        w_char = w_sep_nl ? ASCII_LF : ASCII_SPACE;
        if (tx_rdy) w_next_state = ST_IDLE;
      end
      ST_BANG: begin
        w_emit = 1'b1;
        w_char = ASCII_BANG;
        if (tx_rdy) w_next_state = ST_NL;
      end
      ST_NL: begin
        w_emit = 1'b1;
        w_char = ASCII_LF;
        if (tx_rdy) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte         <= 8'h00;
      r_last         <= 1'b0;
      r_line_cnt     <= 8'h00;
      r_drop_pending <= 1'b0;
      r_drop_cnt     <= 16'h0000;
    end else begin
      if (r_state == ST_FETCH) begin
        r_last <= w_rd_data[8];
        r_byte <= w_rd_data[7:0];
      end
      if (r_state == ST_SEP && tx_rdy) begin
        r_line_cnt <= w_sep_nl ? 8'h00 : r_line_cnt + 8'd1;
      end else if (r_state == ST_NL && tx_rdy) begin
        r_line_cnt <= 8'h00;
      end
      // A fresh overflow outranks the clear so no loss goes unmarked.
      if (w_drop) begin
        r_drop_pending <= 1'b1;
      end else if (r_state == ST_NL && tx_rdy) begin
        r_drop_pending <= 1'b0;
      end
      if (w_drop && r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_usbfs_debug_hex_formatter.sv
// Directed bench for the debug hex formatter: expected text queue checked by a TX monitor.
module tb_usbfs_debug_hex_formatter;
  localparam int ISIZE = 6;
  localparam int DEPTH = 1 << ISIZE;
  localparam int BPL   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_rdy = 1'b1;
  logic [15:0] drop_cnt;

  int          checks = 0;
  int          errors = 0;
  bit          rdy_rand = 1'b0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  usbfs_debug_hex_formatter #(
    .ISIZE          (ISIZE),
    .BYTES_PER_LINE (BPL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_byte  (in_byte),
    .in_valid (in_valid),
    .in_last  (in_last),
    .tx_data  (tx_data),
    .tx_en    (tx_en),
    .tx_rdy   (tx_rdy),
    .drop_cnt (drop_cnt)
  );

  function automatic logic [7:0] nib2asc(input logic [3:0] n);
    if (n <= 4'd9) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  task automatic exp_byte(input logic [7:0] b, input bit nl);
    exp_q.push_back(nib2asc(b[7:4]));
    exp_q.push_back(nib2asc(b[3:0]));
    exp_q.push_back(nl ? 8'h0A : 8'h20);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rdy_rand) tx_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (10) step();
  endtask

  task automatic send_ramp20();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'(i);
      in_last  = (i == 19);
      exp_byte(8'(i), (i == 15) || (i == 19));
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor: every accepted character must be the next expected one.
  always @(negedge clk) begin
    #1;
    if (tx_en === 1'b1) begin
      chk("tx_en_gated", {15'h0, tx_rdy}, 16'h0001);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL stray_char: observed %h expected none", tx_data);
      end
      if (exp_q.size() != 0) chk("tx_char", {8'h00, tx_data}, {8'h00, exp_q.pop_front()});
    end
  end

  initial begin
    int n;
    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_tx_en", {15'h0, tx_en}, 16'h0000);
    chk("rst_tx_data", {8'h00, tx_data}, 16'h0000);
    chk("rst_drop_cnt", drop_cnt, 16'h0000);
    rst = 1'b0;
    repeat (2) step();

    // Single packet {3C, A5 last}: first character three cycles after the write
    exp_byte(8'h3C, 1'b0);
    exp_byte(8'hA5, 1'b1);
    in_valid = 1'b1; in_byte = 8'h3C; in_last = 1'b0;
    step();
    chk("lat_idle", {15'h0, tx_en}, 16'h0000);
    in_byte = 8'hA5; in_last = 1'b1;
    step();
    chk("lat_fetch", {15'h0, tx_en}, 16'h0000);
    in_valid = 1'b0; in_last = 1'b0;
    step();
    chk("lat_first_en", {15'h0, tx_en}, 16'h0001);
    chk("lat_first_char", {8'h00, tx_data}, 16'h0033);
    drain(100);

    // 20-byte ramp: forced break after 0F, packet end after 13
    send_ramp20();
    drain(200);
    chk("line_cnt_cleared", {8'h00, dut.r_line_cnt}, 16'h0000);

    // Same packet with tx_rdy toggling
    rdy_rand = 1'b1;
    send_ramp20();
    drain(2000);
    rdy_rand = 1'b0;
    tx_rdy   = 1'b1;
    step();

    // Overflow: the FSM already holds EE stalled, so the FIFO alone takes the burst
    tx_rdy = 1'b0;
    in_valid = 1'b1; in_byte = 8'hEE; in_last = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    for (int i = 0; i < DEPTH + 3; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'(i);
      step();
    end
    in_valid = 1'b0;
    chk("ovf_drop_cnt", drop_cnt, 16'd3);
    chk("ovf_stalled_en", {15'h0, tx_en}, 16'h0000);
    exp_byte(8'hEE, 1'b0);
    exp_q.push_back(8'h21);
    exp_q.push_back(8'h0A);
    for (int i = 0; i < DEPTH; i++) exp_byte(8'(i), (i % BPL) == BPL - 1);
    tx_rdy = 1'b1;
    drain(1000);
    chk("ovf_drop_hold", drop_cnt, 16'd3);

    // Reset between HI and LO discards the rest of the line and the FIFO
    in_valid = 1'b1; in_byte = 8'h12; in_last = 1'b0;
    step();
    in_byte = 8'h34; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    exp_q.push_back(8'h31);
    n = 0;
    while (tx_en !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("hi_reached", {15'h0, tx_en}, 16'h0001);
    rst = 1'b1;
    step();
    chk("rst_mid_tx_en", {15'h0, tx_en}, 16'h0000);
    chk("rst_mid_drop_cnt", drop_cnt, 16'h0000);
    rst = 1'b0;
    step();
    exp_byte(8'hFF, 1'b1);
    in_valid = 1'b1; in_byte = 8'hFF; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    drain(100);

    // Saturation: 65 writes fill FIFO plus FSM, then 70000 drops in total
    tx_rdy = 1'b0;
    for (int i = 0; i < DEPTH + 1 + 65534; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'(i);
      step();
    end
    chk("sat_fffe", drop_cnt, 16'hFFFE);
    step();
    chk("sat_ffff", drop_cnt, 16'hFFFF);
    repeat (70000 - 65535) step();
    in_valid = 1'b0;
    chk("sat_hold", drop_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
